// File: rtl/mipi_dsi_pkg.sv
// -----------------------------------------------------------------------------
// mipi_dsi_pkg
// Shared definitions for the MIPI receive frame sequencer:
//   - packet data-type (DT) codes for sync, blanking and pixel packets
//   - frame sequencer FSM state encoding
//   - bit positions inside the sticky err vector
//   - dt_is_short(): short/long packet classification from the DT code
// -----------------------------------------------------------------------------
package mipi_dsi_pkg;

    // Sync short packets
    localparam logic [5:0] DT_VSS          = 6'h01;
    localparam logic [5:0] DT_VSE          = 6'h11;
    localparam logic [5:0] DT_HSS          = 6'h21;
    localparam logic [5:0] DT_HSE          = 6'h31;

    // Blanking / null long packets
    localparam logic [5:0] DT_NULL         = 6'h09;
    localparam logic [5:0] DT_BLANK        = 6'h19;

    // Pixel stream long packets
    localparam logic [5:0] DT_RGB888       = 6'h3E;
    localparam logic [5:0] DT_RGB666_LOOSE = 6'h2E;
    localparam logic [5:0] DT_RGB666       = 6'h1E;
    localparam logic [5:0] DT_RGB565       = 6'h0E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_FRAME,
        ST_PAYLOAD,
        ST_DISCARD
    } seq_state_t;

    // Sticky error flag positions
    localparam int ERR_TRUNC    = 0;
    localparam int ERR_UNEXP_DT = 1;
    localparam int ERR_LINE_CNT = 2;
    localparam int ERR_TIMEOUT  = 3;

    // Short packets use DT low nibbles 0x0..0x8; long packets use 0x9..0xF.
    function automatic logic dt_is_short(input logic [5:0] dt);
        return (dt[3:0] <= 4'h8);
    endfunction

endpackage

// File: rtl/mipi_rx_hdr_decode.sv
// -----------------------------------------------------------------------------
// mipi_rx_hdr_decode
// Purely combinational header field extraction for one slicer word.
// Ports:
//   din      in  32  slicer word (header layout: DI, WC LSB, WC MSB, ECC)
//   dt       out  6  data type, DI[5:0]
//   wc       out 16  word count, {WC MSB, WC LSB}
//   is_short out  1  DT denotes a short packet
//   is_pixel out  1  DT is one of the pixel stream types
//   is_blank out  1  DT is blanking or null
// -----------------------------------------------------------------------------
module mipi_rx_hdr_decode
    import mipi_dsi_pkg::*;
(
    input  logic [31:0] din,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        is_short,
    output logic        is_pixel,
    output logic        is_blank
);

    // Virtual channel and ECC are not used by the sequencer.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{din[31:30], din[7:0]};

    assign dt       = din[29:24];
    assign wc       = {din[15:8], din[23:16]};
    assign is_short = dt_is_short(din[29:24]);
    assign is_pixel = (din[29:24] == DT_RGB888)       ||
                      (din[29:24] == DT_RGB666_LOOSE) ||
                      (din[29:24] == DT_RGB666)       ||
                      (din[29:24] == DT_RGB565);
    assign is_blank = (din[29:24] == DT_NULL) || (din[29:24] == DT_BLANK);

endmodule

// File: rtl/mipi_rx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mipi_rx_frame_sequencer
// Consumes the 4-lane slicer word stream, tracks frame/line structure, strips
// CRC/padding from pixel packets and emits a byte-qualified payload stream
// plus vsync/hsync/frame_done strobes. Every output is registered once.
//
// Optional feature: define MIPI_RX_TIMEOUT_EN to add an idle-cycle watchdog
// that forces a resync (err[3]) after TIMEOUT cycles without validin while a
// frame is in progress. Without it err[3] stays 0.
//
// Ports:
//   clk        in   1  core clock
//   rst        in   1  synchronous active-high reset
//   din        in  32  slicer word, first wire byte in [31:24]
//   validin    in   1  din valid
//   pktheader  in   1  din is a packet header (qualified by validin)
//   enable     in   1  0 forces IDLE and drops input
//   err_clr    in   1  clears err (a simultaneous set wins)
//   dout       out 32  payload word
//   dout_valid out  1  dout carries payload
//   dout_bytes out  3  valid bytes in dout, MSB-first
//   line_start out  1  first payload word of a pixel packet
//   vsync      out  1  VSync Start pulse
//   hsync      out  1  HSync Start pulse
//   frame_done out  1  VSync End with the expected line count
//   err        out  4  sticky: truncated, unexpected DT, line count, timeout
//   line_cnt   out 12  pixel packets seen in the current frame
// -----------------------------------------------------------------------------
module mipi_rx_frame_sequencer
    import mipi_dsi_pkg::*;
#(
    parameter int          LANES    = 4,
    parameter logic [11:0] V_ACTIVE = 12'd1200,
    parameter logic [15:0] TIMEOUT  = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        validin,
    input  logic        pktheader,
    input  logic        enable,
    input  logic        err_clr,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic [2:0]  dout_bytes,
    output logic        line_start,
    output logic        vsync,
    output logic        hsync,
    output logic        frame_done,
    output logic [3:0]  err,
    output logic [11:0] line_cnt
);

    localparam logic [15:0] WORD_BYTES   = 16'(LANES);
    localparam logic [2:0]  WORD_BYTES_3 = 3'(LANES);

    seq_state_t  state_q, state_n;
    logic [15:0] rem_q, rem_n;
    logic        first_q, first_n;
    logic [11:0] line_cnt_n;
    logic [3:0]  err_set;
    logic        take_hdr;
    logic        timeout_hit;
    logic [2:0]  beat_bytes;

    logic [31:0] dout_n;
    logic        dout_valid_n, line_start_n, vsync_n, hsync_n, frame_done_n;
    logic [2:0]  dout_bytes_n;

    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_short, hdr_pixel, hdr_blank;

    mipi_rx_hdr_decode u_hdr_decode (
        .din      (din),
        .dt       (hdr_dt),
        .wc       (hdr_wc),
        .is_short (hdr_short),
        .is_pixel (hdr_pixel),
        .is_blank (hdr_blank)
    );

    // Blanking/null and every other non-pixel long DT are skipped alike, so the
    // blanking flag itself does not steer anything here.
    logic unused_blank;
    assign unused_blank = hdr_blank;

`ifdef MIPI_RX_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_n;

    always_comb begin
        idle_cnt_n = idle_cnt_q;
        if (validin)
            idle_cnt_n = '0;
        else if (idle_cnt_q != 16'hFFFF)
            idle_cnt_n = idle_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            idle_cnt_q <= '0;
        else
            idle_cnt_q <= idle_cnt_n;
    end

    // Only a frame in progress can time out; IDLE/WAIT_VS are already resynced.
    assign timeout_hit = !validin && (idle_cnt_n == TIMEOUT) &&
                         ((state_q == ST_FRAME) || (state_q == ST_PAYLOAD) ||
                          (state_q == ST_DISCARD));
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state_q;
        rem_n        = rem_q;
        first_n      = first_q;
        line_cnt_n   = line_cnt;
        err_set      = '0;
        take_hdr     = 1'b0;
        beat_bytes   = '0;
        dout_n       = '0;
        dout_valid_n = 1'b0;
        dout_bytes_n = '0;
        line_start_n = 1'b0;
        vsync_n      = 1'b0;
        hsync_n      = 1'b0;
        frame_done_n = 1'b0;

        if (!enable) begin
            state_n    = ST_IDLE;
            line_cnt_n = '0;
            first_n    = 1'b0;
        end else if (timeout_hit) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_n              = ST_WAIT_VS;
        end else begin
            case (state_q)
                ST_IDLE: state_n = ST_WAIT_VS;

                ST_WAIT_VS: begin
                    if (validin && pktheader && hdr_dt == DT_VSS) begin
                        vsync_n    = 1'b1;
                        line_cnt_n = '0;
                        state_n    = ST_FRAME;
                    end
                end

                // Non-header words (CRC, padding) are dropped silently here.
                ST_FRAME: take_hdr = validin && pktheader;

                ST_PAYLOAD: begin
                    if (validin && pktheader) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        take_hdr           = 1'b1;
                    end else if (validin) begin
                        beat_bytes   = (rem_q >= WORD_BYTES) ? WORD_BYTES_3 : rem_q[2:0];
                        dout_n       = din;
                        dout_valid_n = 1'b1;
                        dout_bytes_n = beat_bytes;
                        line_start_n = first_q;
                        first_n      = 1'b0;
                        rem_n        = rem_q - 16'(beat_bytes);
                        if (rem_n == '0)
                            state_n = ST_FRAME;
                    end
                end

                ST_DISCARD: begin
                    if (validin && pktheader) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        take_hdr           = 1'b1;
                    end else if (validin) begin
                        if (rem_q <= WORD_BYTES) begin
                            rem_n   = '0;
                            state_n = ST_FRAME;
                        end else begin
                            rem_n = rem_q - WORD_BYTES;
                        end
                    end
                end

                default: state_n = ST_IDLE;
            endcase

            // Header handling shared by FRAME and by an abandoned packet.
            if (take_hdr) begin
                state_n = ST_FRAME;
                if (hdr_short) begin
                    case (hdr_dt)
                        DT_VSE: begin
                            if (line_cnt == V_ACTIVE)
                                frame_done_n = 1'b1;
                            else
                                err_set[ERR_LINE_CNT] = 1'b1;
                            state_n = ST_WAIT_VS;
                        end
                        DT_VSS: begin
                            if (line_cnt != '0)
                                err_set[ERR_LINE_CNT] = 1'b1;
                            vsync_n    = 1'b1;
                            line_cnt_n = '0;
                        end
                        DT_HSS:  hsync_n = 1'b1;
                        DT_HSE:  begin end
                        default: err_set[ERR_UNEXP_DT] = 1'b1;
                    endcase
                end else begin
                    rem_n = hdr_wc;
                    if (hdr_wc != '0) begin
                        if (hdr_pixel) begin
                            line_cnt_n = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
                            first_n    = 1'b1;
                            state_n    = ST_PAYLOAD;
                        end else begin
                            state_n = ST_DISCARD;
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            first_q    <= 1'b0;
            line_cnt   <= '0;
            err        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_bytes <= '0;
            line_start <= 1'b0;
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            rem_q      <= rem_n;
            first_q    <= first_n;
            line_cnt   <= line_cnt_n;
            // A flag raised in the same cycle as err_clr survives the clear.
            err        <= (err & ~{4{err_clr}}) | err_set;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            dout_bytes <= dout_bytes_n;
            line_start <= line_start_n;
            vsync      <= vsync_n;
            hsync      <= hsync_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_mipi_rx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mipi_rx_frame_sequencer
// Directed scenarios followed by randomized traffic. A packet-level reference
// model predicts every output for the cycle after each input beat.
// -----------------------------------------------------------------------------
module tb_mipi_rx_frame_sequencer;

    localparam logic [11:0] V_ACT = 12'd2;
    localparam logic [15:0] TMO   = 16'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        validin, pktheader, enable, err_clr;
    logic [31:0] dout;
    logic        dout_valid;
    logic [2:0]  dout_bytes;
    logic        line_start, vsync, hsync, frame_done;
    logic [3:0]  err;
    logic [11:0] line_cnt;

    always #5 clk = ~clk;

    mipi_rx_frame_sequencer #(
        .LANES    (4),
        .V_ACTIVE (V_ACT),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .validin    (validin),
        .pktheader  (pktheader),
        .enable     (enable),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_bytes (dout_bytes),
        .line_start (line_start),
        .vsync      (vsync),
        .hsync      (hsync),
        .frame_done (frame_done),
        .err        (err),
        .line_cnt   (line_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_active;   // left idle after enable
    bit          m_synced;   // VSync Start seen, frame in progress
    bit          m_out;      // current packet is pixel data
    bit          m_first;
    int          m_left;     // payload bytes still owed by the current packet
    int          m_lines;
    int          m_idle;
    logic [3:0]  m_err;
    bit          e_valid, e_ls, e_vs, e_hs, e_fd;
    logic [31:0] e_dout;
    logic [2:0]  e_bytes;

    // observation statistics
    int c_vs, c_hs, c_fd, c_ls, c_valid;
    int q_bytes[$];
    string cur_tag = "init";

    function automatic bit dt_pixel(input int dt);
        return dt == 'h3E || dt == 'h2E || dt == 'h1E || dt == 'h0E;
    endfunction

    task automatic model_reset();
        m_active = 0; m_synced = 0; m_out = 0; m_first = 0;
        m_left = 0; m_lines = 0; m_idle = 0; m_err = '0;
        e_valid = 0; e_ls = 0; e_vs = 0; e_hs = 0; e_fd = 0;
        e_dout = '0; e_bytes = '0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit h,
                              input logic [31:0] d, input bit clr);
        int dt, wc, n;
        bit tmo;
        logic [3:0] set;
        set = '0;
        e_valid = 0; e_ls = 0; e_vs = 0; e_hs = 0; e_fd = 0;
        e_dout = '0; e_bytes = '0;
        dt = int'(d[29:24]);
        wc = int'({d[15:8], d[23:16]});
        m_idle = v ? 0 : ((m_idle < 65535) ? m_idle + 1 : m_idle);
        tmo = 0;
`ifdef MIPI_RX_TIMEOUT_EN
        tmo = !v && (m_idle == int'(TMO)) && m_active && m_synced;
`endif
        if (!en) begin
            m_active = 0; m_synced = 0; m_left = 0; m_lines = 0; m_first = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (tmo) begin
            set[3] = 1; m_synced = 0; m_left = 0;
        end else if (!m_synced) begin
            if (v && h && dt == 'h01) begin
                e_vs = 1; m_lines = 0; m_synced = 1;
            end
        end else if (v && h) begin
            if (m_left > 0) set[0] = 1;
            m_left = 0;
            if ((dt % 16) <= 8) begin
                case (dt)
                    'h11: begin
                        if (m_lines == int'(V_ACT)) e_fd = 1; else set[2] = 1;
                        m_synced = 0;
                    end
                    'h01: begin
                        if (m_lines != 0) set[2] = 1;
                        e_vs = 1; m_lines = 0;
                    end
                    'h21: e_hs = 1;
                    'h31: begin end
                    default: set[1] = 1;
                endcase
            end else if (wc > 0) begin
                m_left = wc;
                m_out  = dt_pixel(dt);
                if (m_out) begin
                    m_first = 1;
                    if (m_lines < 4095) m_lines++;
                end
            end
        end else if (v && m_left > 0) begin
            if (m_out) begin
                n = (m_left < 4) ? m_left : 4;
                e_valid = 1; e_dout = d; e_bytes = 3'(n); e_ls = m_first;
                m_first = 0; m_left -= n;
            end else begin
                m_left = (m_left <= 4) ? 0 : m_left - 4;
            end
        end
        m_err = (clr ? 4'b0 : m_err) | set;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [55:0] get_obs();
        return {dout_valid, dout_bytes, line_start, vsync, hsync, frame_done, err, line_cnt, dout};
    endfunction

    task automatic tick(input bit v, input bit h, input logic [31:0] d);
        logic [55:0] exp;
        validin = v; pktheader = h; din = d;
        model_step(enable, v, h, d, err_clr);
        @(posedge clk); #1;
        exp = {e_valid, e_bytes, e_ls, e_vs, e_hs, e_fd, m_err, 12'(m_lines), e_dout};
        check(cur_tag, 64'(get_obs()), 64'(exp));
        if (dout_valid) begin
            c_valid++;
            q_bytes.push_back(int'(dout_bytes));
        end
        c_ls += int'(line_start); c_vs += int'(vsync);
        c_hs += int'(hsync);      c_fd += int'(frame_done);
        err_clr = 1'b0;
    endtask

    function automatic logic [31:0] mk_hdr(input logic [5:0] dt, input logic [15:0] wc);
        logic [1:0] vc;
        logic [7:0] ecc;
        vc  = 2'($urandom);
        ecc = 8'($urandom);
        return {vc, dt, wc[7:0], wc[15:8], ecc};
    endfunction

    task automatic hdr(input logic [5:0] dt, input logic [15:0] wc);
        tick(1'b1, 1'b1, mk_hdr(dt, wc));
    endtask

    task automatic word();
        tick(1'b1, 1'b0, $urandom);
    endtask

    // Idle beats carry junk on din/pktheader that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), $urandom);
    endtask

    task automatic clr_stats();
        c_vs = 0; c_hs = 0; c_fd = 0; c_ls = 0; c_valid = 0;
        q_bytes.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; validin = 1'b0; pktheader = 1'b0; din = $urandom;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("reset_outputs", 64'(get_obs()), 64'd0);
        end
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int exp_b[4];
        int r;
        rst = 1'b1; enable = 1'b0; validin = 1'b0; pktheader = 1'b0;
        din = '0; err_clr = 1'b0;
        clr_stats();
        do_reset(2);

        cur_tag = "disabled";
        tick(1'b1, 1'b1, mk_hdr(6'h01, 16'd0));
        enable = 1'b1;
        idle(2);

        // 1: well-formed frame of two WC=6 lines
        cur_tag = "t1_frame"; clr_stats();
        hdr(6'h01, 0); hdr(6'h21, 0);
        hdr(6'h3E, 6); word(); word(); word();
        hdr(6'h31, 0); hdr(6'h21, 0);
        hdr(6'h0E, 6); word(); word(); word();
        hdr(6'h11, 0);
        exp_b = '{4, 2, 4, 2};
        check("t1_vsync_cnt", c_vs, 1);
        check("t1_fdone_cnt", c_fd, 1);
        check("t1_lstart_cnt", c_ls, 2);
        check("t1_err", err, 0);
        check("t1_beats", q_bytes.size(), 4);
        foreach (exp_b[i]) if (i < q_bytes.size()) check("t1_bytes", q_bytes[i], exp_b[i]);

        // 2: short frame, then WAIT_VS ignores traffic
        cur_tag = "t2_short_frame"; clr_stats();
        hdr(6'h01, 0); hdr(6'h3E, 6); word(); word(); hdr(6'h11, 0);
        check("t2_err", err, 4'b0100);
        check("t2_fdone_cnt", c_fd, 0);
        clr_stats();
        hdr(6'h3E, 8); word(); word(); hdr(6'h21, 0);
        check("t2_waitvs_valid", c_valid, 0);
        check("t2_waitvs_hsync", c_hs, 0);
        err_clr = 1'b1; idle(1);
        check("t2_err_clr", err, 0);

        // 3: truncated packet, header decoded in the same cycle
        cur_tag = "t3_trunc"; clr_stats();
        hdr(6'h01, 0); hdr(6'h3E, 12); word(); word(); hdr(6'h21, 0);
        check("t3_err", err, 4'b0001);
        check("t3_hsync_cnt", c_hs, 1);
        check("t3_valid_cnt", c_valid, 2);
        err_clr = 1'b1; idle(1);
        clr_stats();
        hdr(6'h1E, 4); word(); hdr(6'h11, 0);
        check("t3_fdone_cnt", c_fd, 1);

        // 4: blanking packet between lines
        cur_tag = "t4_blank"; clr_stats();
        hdr(6'h01, 0); hdr(6'h19, 8); word(); word(); word();
        check("t4_blank_valid", c_valid, 0);
        hdr(6'h2E, 8); word(); word(); word();
        check("t4_pix_valid", c_valid, 2);
        check("t4_lstart_cnt", c_ls, 1);

        // 5: sparse payload
        cur_tag = "t5_sparse"; clr_stats();
        hdr(6'h3E, 16); word(); word(); idle(5); word(); word(); word();
        check("t5_beats", q_bytes.size(), 4);
        foreach (q_bytes[i]) check("t5_bytes", q_bytes[i], 4);
        hdr(6'h11, 0);
        check("t5_fdone_cnt", c_fd, 1);
        check("t5_err", err, 0);

        // 6: error set wins over a simultaneous clear
        cur_tag = "t6_setwins"; clr_stats();
        hdr(6'h01, 0);
        err_clr = 1'b1; hdr(6'h05, 0);
        check("t6_err", err, 4'b0010);
        err_clr = 1'b1; idle(1);
        check("t6_err_clr", err, 0);

        // 7: watchdog boundary
        cur_tag = "t7_timeout"; clr_stats();
        hdr(6'h3E, 8); word();
        idle(19);
        check("t7_before_tmo", err[3], 0);
        idle(1);
`ifdef MIPI_RX_TIMEOUT_EN
        check("t7_at_tmo", err[3], 1);
        clr_stats();
        word(); hdr(6'h21, 0);
        check("t7_waitvs_hsync", c_hs, 0);
`else
        check("t7_at_tmo", err[3], 0);
`endif
        clr_stats();
        hdr(6'h01, 0);
        check("t7_vs_cnt", c_vs, 1);
        check("t7_line_cnt", line_cnt, 0);
        err_clr = 1'b1; idle(1);

        // 8: enable drop mid-packet, err preserved
        cur_tag = "t8_enable"; clr_stats();
        hdr(6'h05, 0); hdr(6'h3E, 16); word();
        enable = 1'b0; clr_stats(); idle(2);
        check("t8_line_cnt", line_cnt, 0);
        check("t8_err_kept", err, 4'b0010);
        enable = 1'b1; idle(1); word(); hdr(6'h3E, 4); word();
        check("t8_valid_cnt", c_valid, 0);
        hdr(6'h01, 0);
        check("t8_vs_cnt", c_vs, 1);

        // 9: reset mid-packet
        cur_tag = "t9_reset";
        hdr(6'h3E, 16); word();
        do_reset(1);
        idle(1); hdr(6'h01, 0);

        // 10: line counter saturation
        cur_tag = "t10_sat";
        for (int i = 0; i < 4100; i++) begin
            hdr(6'h3E, 1); word();
        end
        check("t10_line_sat", line_cnt, 12'hFFF);
        hdr(6'h11, 0);
        check("t10_err", err, 4'b0100);
        err_clr = 1'b1; idle(1);

        // 11: randomized traffic
        cur_tag = "rand";
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       hdr(6'h01, 16'($urandom_range(0, 3)));
            else if (r < 9)  hdr(6'h11, 0);
            else if (r < 15) hdr(($urandom_range(0, 1) != 0) ? 6'h21 : 6'h31, 0);
            else if (r < 35) begin
                case ($urandom_range(0, 3))
                    0: hdr(6'h3E, 16'($urandom_range(0, 20)));
                    1: hdr(6'h2E, 16'($urandom_range(0, 20)));
                    2: hdr(6'h1E, 16'($urandom_range(0, 20)));
                    default: hdr(6'h0E, 16'($urandom_range(0, 20)));
                endcase
            end
            else if (r < 42) hdr(($urandom_range(0, 1) != 0) ? 6'h19 : 6'h09, 16'($urandom_range(0, 12)));
            else if (r < 45) hdr(($urandom_range(0, 1) != 0) ? 6'h29 : 6'h39, 16'($urandom_range(0, 9)));
            else if (r < 47) hdr(($urandom_range(0, 1) != 0) ? 6'h02 : 6'h08, 0);
            else if (r < 80) word();
            else if (r < 95) idle($urandom_range(1, 3));
            else if (r < 97) idle(22);
            else if (r < 98) begin err_clr = 1'b1; word(); end
            else if (r < 99) begin enable = 1'b0; idle($urandom_range(1, 2)); enable = 1'b1; end
            else             do_reset(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
